// File: rtl/ex_issue_buf.sv
// Execute-stage issue buffer: 2-entry skid buffer with operand select and MEM/WB forwarding.
// Optional macro EX_ISSUE_FWD_EN enables forwarding at capture and snooping of held entries.
module ex_issue_buf #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            in_use_pc,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_ctl,
  input  logic            in_sub,
  input  logic            in_sign,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_rd_we,
  input  logic            fm_we,
  input  logic [RW-1:0]   fm_rd,
  input  logic [XLEN-1:0] fm_data,
  input  logic            fw_we,
  input  logic [RW-1:0]   fw_rd,
  input  logic [XLEN-1:0] fw_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_ctl,
  output logic            out_sub,
  output logic            out_sign,
  output logic [RW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]      state, state_nxt;
  logic            accept_c, retire_c;
  logic            load_main_in, load_main_skid, load_skid_in;
  logic [XLEN-1:0] skid_a, skid_b, skid_pc;
  logic [3:0]      skid_alu_ctl;
  logic            skid_sub, skid_sign, skid_rd_we;
  logic [RW-1:0]   skid_rd;
  logic [XLEN-1:0] cap_a, cap_b, main_a_s, main_b_s, skid_a_s, skid_b_s;

  assign accept_c = in_valid & in_ready;
  assign retire_c = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Next state and which slot loads from where; flush overrides everything.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept_c) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (accept_c && retire_c) begin
            load_main_in = 1'b1;
          end else if (accept_c) begin
            state_nxt    = TWO;
            load_skid_in = 1'b1;
          end else if (retire_c) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (retire_c) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

`ifdef EX_ISSUE_FWD_EN
  logic [RW-1:0] main_rs1, main_rs2, skid_rs1, skid_rs2;
  logic          main_a_reg, main_b_reg, skid_a_reg, skid_b_reg;

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] res;
    res = d;
    if (r != '0) begin
      if (fm_we && (fm_rd == r))      res = fm_data;
      else if (fw_we && (fw_rd == r)) res = fw_data;
    end
    return res;
  endfunction

  always_comb begin
    cap_a    = in_use_pc  ? in_pc  : fwd(in_rs1, in_rs1_data);
    cap_b    = in_use_imm ? in_imm : fwd(in_rs2, in_rs2_data);
    main_a_s = main_a_reg ? fwd(main_rs1, out_a)  : out_a;
    main_b_s = main_b_reg ? fwd(main_rs2, out_b)  : out_b;
    skid_a_s = skid_a_reg ? fwd(skid_rs1, skid_a) : skid_a;
    skid_b_s = skid_b_reg ? fwd(skid_rs2, skid_b) : skid_b;
  end

  // Source tags that let held operands keep tracking later writers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_rs1   <= '0;
      main_rs2   <= '0;
      main_a_reg <= 1'b0;
      main_b_reg <= 1'b0;
      skid_rs1   <= '0;
      skid_rs2   <= '0;
      skid_a_reg <= 1'b0;
      skid_b_reg <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_rs1   <= in_rs1;
        main_rs2   <= in_rs2;
        main_a_reg <= !in_use_pc;
        main_b_reg <= !in_use_imm;
      end else if (load_main_skid) begin
        main_rs1   <= skid_rs1;
        main_rs2   <= skid_rs2;
        main_a_reg <= skid_a_reg;
        main_b_reg <= skid_b_reg;
      end
      if (load_skid_in) begin
        skid_rs1   <= in_rs1;
        skid_rs2   <= in_rs2;
        skid_a_reg <= !in_use_pc;
        skid_b_reg <= !in_use_imm;
      end
    end
  end
`else
  always_comb begin
    cap_a    = in_use_pc  ? in_pc  : in_rs1_data;
    cap_b    = in_use_imm ? in_imm : in_rs2_data;
    main_a_s = out_a;
    main_b_s = out_b;
    skid_a_s = skid_a;
    skid_b_s = skid_b;
  end

  logic unused_fwd;
  assign unused_fwd = ^{in_rs1, in_rs2, fm_we, fm_rd, fm_data, fw_we, fw_rd, fw_data};
`endif

  // Main slot drives out_*; skid slot holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a        <= '0;
      out_b        <= '0;
      out_alu_ctl  <= '0;
      out_sub      <= 1'b0;
      out_sign     <= 1'b0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_pc       <= '0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_alu_ctl <= '0;
      skid_sub     <= 1'b0;
      skid_sign    <= 1'b0;
      skid_rd      <= '0;
      skid_rd_we   <= 1'b0;
      skid_pc      <= '0;
    end else begin
      if (load_main_in) begin
        out_a       <= cap_a;
        out_b       <= cap_b;
        out_alu_ctl <= in_alu_ctl;
        out_sub     <= in_sub;
        out_sign    <= in_sign;
        out_rd      <= in_rd;
        out_rd_we   <= in_rd_we;
        out_pc      <= in_pc;
      end else if (load_main_skid) begin
        out_a       <= skid_a_s;
        out_b       <= skid_b_s;
        out_alu_ctl <= skid_alu_ctl;
        out_sub     <= skid_sub;
        out_sign    <= skid_sign;
        out_rd      <= skid_rd;
        out_rd_we   <= skid_rd_we;
        out_pc      <= skid_pc;
      end else begin
        out_a <= main_a_s;
        out_b <= main_b_s;
      end
      if (load_skid_in) begin
        skid_a       <= cap_a;
        skid_b       <= cap_b;
        skid_alu_ctl <= in_alu_ctl;
        skid_sub     <= in_sub;
        skid_sign    <= in_sign;
        skid_rd      <= in_rd;
        skid_rd_we   <= in_rd_we;
        skid_pc      <= in_pc;
      end else begin
        skid_a <= skid_a_s;
        skid_b <= skid_b_s;
      end
    end
  end

endmodule

// File: tb/tb_ex_issue_buf.sv
// Bench for ex_issue_buf: directed scenarios plus random traffic against a queue-based model.
// Honours EX_ISSUE_FWD_EN the same way the design does.
module tb_ex_issue_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_pc, in_use_imm, in_sub, in_sign, in_rd_we;
  logic [3:0]  in_alu_ctl;
  logic        fm_we, fw_we;
  logic [4:0]  fm_rd, fw_rd;
  logic [31:0] fm_data, fw_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_pc;
  logic [3:0]  out_alu_ctl;
  logic        out_sub, out_sign, out_rd_we;
  logic [4:0]  out_rd;

  ex_issue_buf #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_alu_ctl(in_alu_ctl), .in_sub(in_sub), .in_sign(in_sign),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .fm_we(fm_we), .fm_rd(fm_rd), .fm_data(fm_data),
    .fw_we(fw_we), .fw_rd(fw_rd), .fw_data(fw_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctl(out_alu_ctl),
    .out_sub(out_sub), .out_sign(out_sign), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        a_reg, b_reg, sub, sign, rd_we;
    logic [3:0]  ctl;
  } ent_t;

  ent_t q[$];
  bit   m_rdy = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef EX_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
    if (!FWD || r == 5'd0) return d;
    if (fm_we && fm_rd == r) return fm_data;
    if (fw_we && fw_rd == r) return fw_data;
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; retire pops, flush clears, held register operands track writers.
  task automatic model_step();
    bit   acc, ret;
    ent_t e;
    acc = in_valid && m_rdy;
    ret = (q.size() > 0) && out_ready;
    if (ret) void'(q.pop_front());
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      if (e.a_reg) e.a = mfwd(e.rs1, e.a);
      if (e.b_reg) e.b = mfwd(e.rs2, e.b);
      q[i] = e;
    end
    if (flush) q.delete();
    else if (acc) begin
      e.a = in_use_pc ? in_pc : mfwd(in_rs1, in_rs1_data);
      e.b = in_use_imm ? in_imm : mfwd(in_rs2, in_rs2_data);
      e.rs1 = in_rs1; e.rs2 = in_rs2;
      e.a_reg = !in_use_pc; e.b_reg = !in_use_imm;
      e.ctl = in_alu_ctl; e.sub = in_sub; e.sign = in_sign;
      e.rd = in_rd; e.rd_we = in_rd_we; e.pc = in_pc;
      q.push_back(e);
    end
    m_rdy = (q.size() < 2);
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_a", out_a, q[0].a);
      check("out_b", out_b, q[0].b);
      check("out_pc", out_pc, q[0].pc);
      check("out_ctl", 32'({out_alu_ctl, out_sub, out_sign, out_rd, out_rd_we}),
            32'({q[0].ctl, q[0].sub, q[0].sign, q[0].rd, q[0].rd_we}));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_pc = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_use_pc = 0; in_use_imm = 0;
    in_alu_ctl = 0; in_sub = 0; in_sign = 0; in_rd = 0; in_rd_we = 0;
    fm_we = 0; fm_rd = 0; fm_data = 0; fw_we = 0; fw_rd = 0; fw_data = 0;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic use_imm);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2;
    in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm; in_use_pc = 0;
    in_alu_ctl = pc[3:0]; in_rd = pc[8:4]; in_rd_we = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    q.delete(); m_rdy = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle();
    out_ready = 1;
    #1 rst_n = 0;
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_out_b", out_b, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Single issue.
    set_in(32'h100, 5'd5, 32'h10, 5'd0, 32'h0, 32'h4, 1'b1);
    step();
    in_valid = 0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_a", out_a, 32'h10);
    check("single_b", out_b, 32'h4);

    // MEM beats WB; x0 never forwarded.
    set_in(32'h200, 5'd3, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1);
    fm_we = 1; fm_rd = 3; fm_data = 32'hAA; fw_we = 1; fw_rd = 3; fw_data = 32'hBB;
    step();
    check("fwd_mem_prio", out_a, FWD ? 32'hAA : 32'h1);
    in_rs1 = 0; in_pc = 32'h204;
    step();
    check("fwd_x0", out_a, 32'h1);
    idle();
    step();

    // Backpressure: two accepted, third held until space.
    out_ready = 0;
    set_in(32'h300, 5'd1, 32'h31, 5'd2, 32'h32, 32'h0, 1'b0); step();
    set_in(32'h310, 5'd1, 32'h41, 5'd2, 32'h42, 32'h0, 1'b0); step();
    check("bp_full", 32'(in_ready), 32'd0);
    set_in(32'h320, 5'd1, 32'h51, 5'd2, 32'h52, 32'h0, 1'b0); step();
    check("bp_hold_pc", out_pc, 32'h300);
    out_ready = 1; step();
    check("bp_second", out_pc, 32'h310);
    step();
    check("bp_third", out_pc, 32'h320);
    in_valid = 0; step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Stall snoop.
    out_ready = 0;
    set_in(32'h400, 5'd0, 32'h0, 5'd7, 32'h11, 32'h0, 1'b0); step();
    in_valid = 0; fw_we = 1; fw_rd = 7; fw_data = 32'h55; step();
    check("snoop_b", out_b, FWD ? 32'h55 : 32'h11);
    fw_we = 0; step();
    check("snoop_keep", out_b, FWD ? 32'h55 : 32'h11);
    out_ready = 1; step();

    // Flush in TWO with a simultaneous input.
    out_ready = 0;
    set_in(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0); step();
    set_in(32'h510, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0); step();
    set_in(32'hDEAD, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0); flush = 1; step();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    flush = 0; in_valid = 0; out_ready = 1; step();
    check("flush_gone", 32'(out_valid), 32'd0);

    // Async reset while in TWO.
    out_ready = 0;
    set_in(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0); step();
    set_in(32'h610, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0); step();
    in_valid = 0;
    do_reset();
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      in_pc       = $urandom;
      in_imm      = $urandom;
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_use_pc   = ($urandom_range(0, 3) == 0);
      in_use_imm  = ($urandom_range(0, 2) == 0);
      in_alu_ctl  = 4'($urandom);
      in_sub      = 1'($urandom);
      in_sign     = 1'($urandom);
      in_rd       = 5'($urandom);
      in_rd_we    = 1'($urandom);
      fm_we       = 1'($urandom);
      fm_rd       = 5'($urandom_range(0, 7));
      fm_data     = $urandom;
      fw_we       = 1'($urandom);
      fw_rd       = 5'($urandom_range(0, 7));
      fw_data     = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
